// File: rtl/disp_pkg.sv
// Shared types and video timing constants for the display mode controller.
package disp_pkg;

    typedef enum logic {
        MODE_VGA = 1'b0,
        MODE_XGA = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        SWITCH,
        WAIT_LOCK,
        RST_HOLD,
        SETTLE
    } state_e;

    localparam int VGA_HTOTAL = 800;
    localparam int VGA_VTOTAL = 525;
    localparam int XGA_HTOTAL = 1344;
    localparam int XGA_VTOTAL = 806;

    function automatic mode_e to_mode(input logic b);
        return b ? MODE_XGA : MODE_VGA;
    endfunction

endpackage

// File: rtl/disp_sync_edge.sv
// Two-flop synchroniser with falling-edge detect of the synchronised level.
module disp_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic DCLK,
    input  logic RST,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_q;
    logic prev_q;

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            meta_q <= RST_VAL;
            dout   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            dout   <= meta_q;
            prev_q <= dout;
        end
    end

    assign fall = prev_q & ~dout;

endmodule

// File: rtl/disp_mode_ctrl.sv
// VGA/XGA mode-change sequencer: blanks, holds patgen in reset across a pixel clock switch.
// Optional lock timeout with clock revert is enabled by defining DISP_LOCK_TIMEOUT_EN.
module disp_mode_ctrl
    import disp_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_FRAMES = 2,
    parameter int LOCK_TIMEOUT  = 1048576
) (
    input  logic DCLK,
    input  logic RST,
    input  logic BTNR_TGL,
    input  logic DSP_VSYNC_X,
    input  logic CLK_ACK,
    input  logic LOCKED,
    output logic XGA,
    output logic CLK_SEL,
    output logic CLK_REQ,
    output logic PG_RST,
    output logic BLANK,
    output logic BUSY,
    output logic ERR
);

    localparam int CNT_W  = $clog2(RST_CYCLES + 1);
    localparam int FCNT_W = $clog2(SETTLE_FRAMES + 1);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [FCNT_W-1:0]   fcnt;
    mode_e               mode_q;
    logic                clk_sel_q;
    logic                clk_req_q;
    logic                pg_rst_q;
    logic                blank_q;

    logic tgl_s, lock_s, vs_fall;
    logic tgl_fall_unused, lock_fall_unused, vs_s_unused;

    disp_sync_edge #(.RST_VAL(1'b0)) u_sync_tgl (
        .DCLK (DCLK),
        .RST  (RST),
        .din  (BTNR_TGL),
        .dout (tgl_s),
        .fall (tgl_fall_unused)
    );

    disp_sync_edge #(.RST_VAL(1'b0)) u_sync_lock (
        .DCLK (DCLK),
        .RST  (RST),
        .din  (LOCKED),
        .dout (lock_s),
        .fall (lock_fall_unused)
    );

    // vsync idles high, so reset the chain high to avoid a fake edge after reset
    disp_sync_edge #(.RST_VAL(1'b1)) u_sync_vs (
        .DCLK (DCLK),
        .RST  (RST),
        .din  (DSP_VSYNC_X),
        .dout (vs_s_unused),
        .fall (vs_fall)
    );

`ifdef DISP_LOCK_TIMEOUT_EN
    localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;
    logic              err_q;
    assign ERR = err_q;
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = (LOCK_TIMEOUT == 0);
    assign ERR = 1'b0;
`endif

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            fcnt      <= '0;
            mode_q    <= MODE_VGA;
            clk_sel_q <= 1'b0;
            clk_req_q <= 1'b0;
            pg_rst_q  <= 1'b1;
            blank_q   <= 1'b1;
`ifdef DISP_LOCK_TIMEOUT_EN
            tcnt      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        pg_rst_q <= 1'b1;
                        blank_q  <= 1'b1;
`ifdef DISP_LOCK_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                    end else if (to_mode(tgl_s) != mode_q) begin
                        state <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state     <= SWITCH;
                        blank_q   <= 1'b1;
                        pg_rst_q  <= 1'b1;
                        clk_sel_q <= tgl_s;
                        clk_req_q <= 1'b1;
                    end
                end
                SWITCH: begin
                    if (CLK_ACK) begin
                        clk_req_q <= 1'b0;
                        state     <= WAIT_LOCK;
`ifdef DISP_LOCK_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end else begin
                        clk_req_q <= 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= RST_HOLD;
                        cnt   <= '0;
`ifdef DISP_LOCK_TIMEOUT_EN
                    end else if (tcnt == TCNT_W'(LOCK_TIMEOUT - 1)) begin
                        // revert to the committed clock; if already there just keep waiting
                        err_q     <= 1'b1;
                        clk_sel_q <= mode_q;
                        tcnt      <= '0;
                        if (clk_sel_q != mode_q) begin
                            state     <= SWITCH;
                            clk_req_q <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                RST_HOLD: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        pg_rst_q <= 1'b0;
                        mode_q   <= to_mode(clk_sel_q);
                        fcnt     <= '0;
                        state    <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        pg_rst_q <= 1'b1;
                        blank_q  <= 1'b1;
`ifdef DISP_LOCK_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                    end else if (fcnt == FCNT_W'(SETTLE_FRAMES)) begin
                        state   <= IDLE;
                        blank_q <= 1'b0;
                    end else if (vs_fall) begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    state    <= WAIT_LOCK;
                    pg_rst_q <= 1'b1;
                    blank_q  <= 1'b1;
                end
            endcase
        end
    end

    assign XGA     = mode_q;
    assign CLK_SEL = clk_sel_q;
    assign CLK_REQ = clk_req_q;
    assign PG_RST  = pg_rst_q;
    assign BLANK   = blank_q;
    assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed bench for disp_mode_ctrl; the lock-timeout scenario runs when DISP_LOCK_TIMEOUT_EN is defined.
module tb_disp_mode_ctrl;

`ifdef DISP_LOCK_TIMEOUT_EN
    localparam int LTO = 64;
`else
    localparam int LTO = 1048576;
`endif

    logic DCLK = 1'b0;
    logic RST, BTNR_TGL, DSP_VSYNC_X, CLK_ACK, LOCKED;
    logic XGA, CLK_SEL, CLK_REQ, PG_RST, BLANK, BUSY, ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    disp_mode_ctrl #(
        .RST_CYCLES    (16),
        .SETTLE_FRAMES (2),
        .LOCK_TIMEOUT  (LTO)
    ) dut (
        .DCLK        (DCLK),
        .RST         (RST),
        .BTNR_TGL    (BTNR_TGL),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .CLK_ACK     (CLK_ACK),
        .LOCKED      (LOCKED),
        .XGA         (XGA),
        .CLK_SEL     (CLK_SEL),
        .CLK_REQ     (CLK_REQ),
        .PG_RST      (PG_RST),
        .BLANK       (BLANK),
        .BUSY        (BUSY),
        .ERR         (ERR)
    );

    always #5 DCLK = ~DCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge DCLK);
            @(negedge DCLK);
        end
    endtask

    // one vsync low pulse; the falling edge takes effect on the third edge
    task automatic vs_pulse();
        DSP_VSYNC_X = 1'b0;
        tick(3);
        DSP_VSYNC_X = 1'b1;
        tick(3);
    endtask

    task automatic ack_pulse();
        CLK_ACK = 1'b1;
        tick(1);
        CLK_ACK = 1'b0;
    endtask

    // sel 0 = PG_RST, 1 = ERR; returns edges elapsed (limit on expiry)
    task automatic wait_for(input int sel, input logic val, input int limit, output int cyc);
        logic s;
        cyc = 0;
        while (cyc < limit) begin
            tick(1);
            cyc++;
            s = (sel == 0) ? PG_RST : ERR;
            if (s == val) break;
        end
    endtask

    initial begin
        RST = 1'b1; BTNR_TGL = 1'b0; DSP_VSYNC_X = 1'b1; CLK_ACK = 1'b0; LOCKED = 1'b1;
        repeat (3) @(negedge DCLK);

        chk("rst_xga",     XGA,     1'b0);
        chk("rst_clk_sel", CLK_SEL, 1'b0);
        chk("rst_clk_req", CLK_REQ, 1'b0);
        chk("rst_pg_rst",  PG_RST,  1'b1);
        chk("rst_blank",   BLANK,   1'b1);
        chk("rst_busy",    BUSY,    1'b1);
        chk("rst_err",     ERR,     1'b0);

        // power-up: 2 sync + 1 transition + 16 hold cycles
        RST = 1'b0;
        wait_for(0, 1'b0, 100, n);
        chk("t1_release_cyc", n, 19);
        chk("t1_blank_held", BLANK, 1'b1);
        chk("t1_xga", XGA, 1'b0);
        vs_pulse();
        chk("t1_blank_after_1vs", BLANK, 1'b1);
        vs_pulse();
        chk("t1_blank_after_2vs", BLANK, 1'b0);
        chk("t1_busy", BUSY, 1'b0);

        // toggle to XGA mid-frame: nothing happens until vsync
        BTNR_TGL = 1'b1;
        tick(6);
        chk("t2_busy_wait_vs", BUSY, 1'b1);
        chk("t2_blank_pre_vs", BLANK, 1'b0);
        chk("t2_clk_sel_pre_vs", CLK_SEL, 1'b0);
        vs_pulse();
        chk("t2_blank", BLANK, 1'b1);
        chk("t2_pg_rst", PG_RST, 1'b1);
        chk("t2_clk_sel", CLK_SEL, 1'b1);
        chk("t2_clk_req", CLK_REQ, 1'b1);
        LOCKED = 1'b0;
        tick(4);
        chk("t2_clk_req_held", CLK_REQ, 1'b1);
        ack_pulse();
        chk("t2_clk_req_drop", CLK_REQ, 1'b0);
        tick(5);
        chk("t2_pg_rst_unlocked", PG_RST, 1'b1);
        chk("t2_xga_unlocked", XGA, 1'b0);
        LOCKED = 1'b1;
        tick(6);
        // toggle back during RST_HOLD is ignored until IDLE
        BTNR_TGL = 1'b0;
        wait_for(0, 1'b0, 100, n);
        chk("t3_release_cyc", n, 13);
        chk("t3_xga", XGA, 1'b1);
        vs_pulse();
        vs_pulse();
        chk("t3_blank_low", BLANK, 1'b0);
        tick(2);
        chk("t3_second_busy", BUSY, 1'b1);
        chk("t3_clk_sel_kept", CLK_SEL, 1'b1);
        vs_pulse();
        chk("t3_clk_sel_vga", CLK_SEL, 1'b0);
        chk("t3_clk_req", CLK_REQ, 1'b1);
        ack_pulse();
        wait_for(0, 1'b0, 100, n);
        chk("t3_release2_cyc", n, 17);
        chk("t3_xga_vga", XGA, 1'b0);
        vs_pulse();
        vs_pulse();
        chk("t3_idle_blank", BLANK, 1'b0);
        chk("t3_idle_busy", BUSY, 1'b0);

        // lock loss in IDLE
        LOCKED = 1'b0;
        tick(3);
        chk("t4_pg_rst", PG_RST, 1'b1);
        chk("t4_blank", BLANK, 1'b1);
        LOCKED = 1'b1;
        wait_for(0, 1'b0, 100, n);
        chk("t4_release_cyc", n, 19);
        chk("t4_xga", XGA, 1'b0);
        vs_pulse();
        vs_pulse();
        chk("t4_blank_low", BLANK, 1'b0);

        // reset while in SWITCH
        BTNR_TGL = 1'b1;
        tick(6);
        vs_pulse();
        chk("t5_in_switch", CLK_REQ, 1'b1);
        RST = 1'b1;
        #1;
        chk("t5_xga",     XGA,     1'b0);
        chk("t5_clk_sel", CLK_SEL, 1'b0);
        chk("t5_clk_req", CLK_REQ, 1'b0);
        chk("t5_pg_rst",  PG_RST,  1'b1);
        chk("t5_blank",   BLANK,   1'b1);
        chk("t5_busy",    BUSY,    1'b1);
        @(negedge DCLK);
        BTNR_TGL = 1'b0;
        tick(2);
        RST = 1'b0;

`ifdef DISP_LOCK_TIMEOUT_EN
        wait_for(0, 1'b0, 100, n);
        chk("t6_release_cyc", n, 19);
        vs_pulse();
        vs_pulse();
        BTNR_TGL = 1'b1;
        tick(6);
        vs_pulse();
        chk("t6_clk_sel", CLK_SEL, 1'b1);
        LOCKED = 1'b0;
        tick(3);
        ack_pulse();
        chk("t6_err_pre", ERR, 1'b0);
        wait_for(1, 1'b1, 200, n);
        chk("t6_err_cyc", n, 64);
        chk("t6_clk_sel_revert", CLK_SEL, 1'b0);
        chk("t6_clk_req", CLK_REQ, 1'b1);
`else
        tick(25);
        chk("t5_err_tied", ERR, 1'b0);
        chk("t5_after_xga", XGA, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
